// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing a single-port instruction memory between fetch and loader.
// Optional loader lock (exclusive burst ownership) is built with `define IMEM_ARB_LOCK_EN.
module imem_port_arbiter #(
  parameter int          DEPTH    = 128,
  parameter int          IDX_W    = 7,
  parameter logic [31:0] NOP_WORD = 32'h0000000D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_req,
  input  logic [31:0]      f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
  output logic             f_err,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [31:0]      l_addr,
  input  logic [31:0]      l_wdata,
  input  logic             l_lock,
  output logic             l_gnt,
  output logic             l_rvalid,
  output logic [31:0]      l_rdata,
  output logic             l_err,
  output logic             m_en,
  output logic             m_we,
  output logic [IDX_W-1:0] m_idx,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  output logic [15:0]      stall_cnt
);

  // Handshake: a requester holds req; every cycle with req=1 and gnt=1 is one accepted
  // access, and its response (rvalid, plus err/rdata) appears exactly one cycle later.

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:IDX_W+2] == '0);
  endfunction

  logic f_legal, l_legal;
  logic last;
  logic resp_valid, resp_owner, resp_err, resp_we;
  logic [31:0] resp_data;

  assign f_legal = is_legal(f_addr);
  assign l_legal = is_legal(l_addr);

`ifdef IMEM_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state, state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB;
    else        state <= state_next;
  end
`endif

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
`ifdef IMEM_ARB_LOCK_EN
    state_next = state;
`endif
    if (rst_n) begin
`ifdef IMEM_ARB_LOCK_EN
      if (state == LOCKED) begin
        l_gnt      = l_req;
        state_next = (l_req && l_lock) ? LOCKED : ARB;
      end else begin
        if (f_req && l_req) begin
          f_gnt = last;
          l_gnt = !last;
        end else begin
          f_gnt = f_req;
          l_gnt = l_req;
        end
        if (l_gnt && l_lock) state_next = LOCKED;
      end
`else
      if (f_req && l_req) begin
        f_gnt = last;
        l_gnt = !last;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
`endif
    end
  end

  always_comb begin
    m_en    = (f_gnt && f_legal) || (l_gnt && l_legal);
    m_we    = l_gnt && l_legal && l_we;
    m_idx   = '0;
    m_wdata = m_we ? l_wdata : 32'h0;
    if (m_en) m_idx = l_gnt ? l_addr[IDX_W+1:2] : f_addr[IDX_W+1:2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= 1'b1;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
      stall_cnt  <= 16'h0;
    end else begin
      if (f_gnt || l_gnt) last <= l_gnt;
      resp_valid <= f_gnt || l_gnt;
      resp_owner <= l_gnt;
      resp_err   <= l_gnt ? !l_legal : !f_legal;
      resp_we    <= l_gnt && l_we;
      if (f_req && !f_gnt && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // A write acknowledge carries no data, even when the write was trapped.
  always_comb begin
    resp_data = m_rdata;
    if (resp_we)       resp_data = 32'h0;
    else if (resp_err) resp_data = NOP_WORD;
  end

  assign f_rvalid = resp_valid && !resp_owner;
  assign l_rvalid = resp_valid && resp_owner;
  assign f_err    = f_rvalid && resp_err;
  assign l_err    = l_rvalid && resp_err;
  assign f_rdata  = f_rvalid ? resp_data : 32'h0;
  assign l_rdata  = l_rvalid ? resp_data : 32'h0;

endmodule
